prim_packer_unit: RTL and testbench

Unit-granular, parametrised data packer/unpacker. It accepts InW-bit words carrying a per-unit contiguous enable mask and compacts the enabled units into OutW-bit output words, with InW ≤ OutW or InW > OutW. Flush is a handshaked drain that blocks new input. The block also exposes its fill level and a sticky protocol-error flag. It sits between streaming producers and width-mismatched consumers, for example DMA or SPI/TL-UL adapters.

---
 rtl/prim_packer_unit.sv | 171 +++++++++++++++++
 tb/tb_prim_packer_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_packer_unit.sv
// prim_packer_unit: unit-granular packer/unpacker. Accepts InW-bit words with a
// contiguous per-unit enable mask and compacts the enabled units into OutW-bit
// output words. Supports a handshaked flush (drain) and a sticky mask-error flag.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready are
// both high (valid_i/ready_o on input, valid_o/ready_i on output). ready_o and
// valid_o depend only on registered state, never on valid_i or ready_i.
//
// Optional feature: define PRIM_PACKER_UNIT_PAD_EN to drive PadVal into the unused
// units of partial drain words and to report mask_o as all ones while valid_o=1.
module prim_packer_unit #(
    parameter int unsigned      InW    = 32,
    parameter int unsigned      OutW   = 32,
    parameter int unsigned      UnitW  = 8,
    parameter logic [UnitW-1:0] PadVal = '0,
    localparam int unsigned     InU    = InW / UnitW,
    localparam int unsigned     OutU   = OutW / UnitW,
    localparam int unsigned     PtrW   = $clog2(InU + OutU + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [InW-1:0]  data_i,
    input  logic [InU-1:0]  mask_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [OutW-1:0] data_o,
    output logic [OutU-1:0] mask_o,
    input  logic            ready_i,
    input  logic            flush_i,
    output logic            flush_done_o,
    output logic [PtrW-1:0] level_o,
    output logic            err_o,
    input  logic            clr_err_i
);

    localparam int unsigned TotU = InU + OutU;
    localparam int unsigned TotW = TotU * UnitW;
    localparam int unsigned LsbW = (InU > 1) ? $clog2(InU) : 1;

    typedef enum logic {
        StIdle,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [TotW-1:0] data_q, data_d;
    logic [TotU-1:0] mask_q, mask_d;
    logic [PtrW-1:0] pos_q, pos_d;
    logic            err_q, err_d;

    logic [LsbW-1:0] lsb;
    logic [PtrW-1:0] pc;
    logic [InW-1:0]  aligned_data;
    logic [InW-1:0]  keep_bits;
    logic [InU-1:0]  keep_units;
    logic [InU:0]    aligned_mask;
    logic            contiguous;
    logic            ack_in;
    logic            ack_out;
    logic [TotW-1:0] data_w;
    logic [TotU-1:0] mask_w;
    logic [PtrW-1:0] pos_w;

    // Handshake outputs come straight from registered state.
    assign ready_o      = (pos_q <= PtrW'(OutU)) && (state_q == StIdle);
    assign valid_o      = (pos_q >= PtrW'(OutU)) || ((state_q == StDrain) && (pos_q != '0));
    assign flush_done_o = (state_q == StDrain) && (pos_q == '0);
    assign level_o      = pos_q;
    assign err_o        = err_q;
    assign ack_in       = valid_i && ready_o;
    assign ack_out      = valid_o && ready_i;

    // Right-align the enabled units and build the unit/bit keep masks (popcount wide).
    always_comb begin
        lsb = '0;
        pc  = '0;
        for (int i = InU - 1; i >= 0; i--) begin
            if (mask_i[i]) lsb = LsbW'(i);
        end
        for (int i = 0; i < InU; i++) begin
            pc = pc + PtrW'(mask_i[i]);
        end
        aligned_data = data_i >> (lsb * UnitW);
        aligned_mask = {1'b0, mask_i} >> lsb;
        contiguous   = ((aligned_mask + {{InU{1'b0}}, 1'b1}) & aligned_mask) == '0;
        keep_units   = '0;
        keep_bits    = '0;
        for (int k = 0; k < InU; k++) begin
            keep_units[k]                 = (PtrW'(k) < pc);
            keep_bits[k*UnitW +: UnitW]   = {UnitW{keep_units[k]}};
        end
    end

    // Next-state: insert at pos, then shift out a word, then apply flush FSM and error flag.
    always_comb begin
        data_w = data_q;
        mask_w = mask_q;
        pos_w  = pos_q;
        if (ack_in) begin
            data_w = data_q | (TotW'(aligned_data & keep_bits) << (pos_q * UnitW));
            mask_w = mask_q | (TotU'(keep_units) << pos_q);
            pos_w  = pos_q + pc;
        end

        data_d = data_w;
        mask_d = mask_w;
        pos_d  = pos_w;
        if (ack_out) begin
            data_d = data_w >> OutW;
            mask_d = mask_w >> OutU;
            pos_d  = (pos_w > PtrW'(OutU)) ? (pos_w - PtrW'(OutU)) : '0;
        end

        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (flush_i) state_d = StDrain;
            end
            StDrain: begin
                // Drain completes once empty; flush_i is not looked at here.
                if (pos_q == '0) begin
                    state_d = StIdle;
                    data_d  = '0;
                    mask_d  = '0;
                    pos_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new error outranks a clear in the same cycle.
        err_d = err_q;
        if (clr_err_i) err_d = 1'b0;
        if (valid_i && !contiguous) err_d = 1'b1;
    end

    // All state registers, asynchronously reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            data_q  <= '0;
            mask_q  <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            pos_q   <= pos_d;
            err_q   <= err_d;
        end
    end

    // Output word view of the lowest storage units, with optional padding.
    always_comb begin
        data_o = data_q[OutW-1:0];
        mask_o = mask_q[OutU-1:0];
`ifdef PRIM_PACKER_UNIT_PAD_EN
        if (valid_o) begin
            mask_o = '1;
            for (int i = 0; i < OutU; i++) begin
                if (PtrW'(i) >= pos_q) data_o[i*UnitW +: UnitW] = PadVal;
            end
        end
`else
        // Storage above pos is always zero, so partial words carry zeros there.
`endif
    end

endmodule

// File: tb/tb_prim_packer_unit.sv
// tb_prim_packer_unit: table vectors, hand sequences and random traffic for
// prim_packer_unit (InW=32, OutW=64, UnitW=8, PadVal=8'hEE). The reference is a
// queue of stored bytes plus a drain flag and an error flag.
module tb_prim_packer_unit;

    localparam logic [7:0] PAD = 8'hEE;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [31:0] data_i;
    logic [3:0]  mask_i;
    logic        ready_o;
    logic        valid_o;
    logic [63:0] data_o;
    logic [7:0]  mask_o;
    logic        ready_i;
    logic        flush_i;
    logic        flush_done_o;
    logic [3:0]  level_o;
    logic        err_o;
    logic        clr_err_i;

    int total = 0;
    int bad   = 0;
    string phase = "reset";

    // Reference model state.
    logic [7:0] m_q[$];
    bit         m_drain;
    bit         m_err;
    logic        e_valid, e_ready, e_done, e_err;
    logic [3:0]  e_level;
    logic [63:0] e_data;
    logic [7:0]  e_mask;

    prim_packer_unit #(
        .InW(32), .OutW(64), .UnitW(8), .PadVal(PAD)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .data_i(data_i),
        .mask_i(mask_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
        .mask_o(mask_o), .ready_i(ready_i), .flush_i(flush_i),
        .flush_done_o(flush_done_o), .level_o(level_o), .err_o(err_o),
        .clr_err_i(clr_err_i)
    );

    // Clock.
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %h want %h", phase, name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_drain = 0;
        m_err   = 0;
    endtask

    // Expected outputs from the stored-byte queue.
    task automatic model_outputs();
        int n;
        n       = m_q.size();
        e_level = 4'(n);
        e_ready = (n <= 8) && !m_drain;
        e_valid = (n >= 8) || (m_drain && n > 0);
        e_done  = m_drain && (n == 0);
        e_err   = m_err;
        e_data  = '0;
        e_mask  = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                e_data[i*8 +: 8] = m_q[i];
                e_mask[i]        = 1'b1;
            end
`ifdef PRIM_PACKER_UNIT_PAD_EN
            else if (e_valid) e_data[i*8 +: 8] = PAD;
`endif
        end
`ifdef PRIM_PACKER_UNIT_PAD_EN
        if (e_valid) e_mask = '1;
`endif
    endtask

    // Apply the cycle's handshakes to the model (uses current inputs).
    task automatic model_advance();
        int lsb, pc, mi;
        bit ain, aout, contig;
        logic [31:0] d;
        d   = data_i;
        mi  = int'(mask_i);
        pc  = $countones(mask_i);
        lsb = 0;
        for (int k = 3; k >= 0; k--) if (mask_i[k]) lsb = k;
        contig = (mi == (((1 << pc) - 1) << lsb));
        ain  = valid_i && e_ready;
        aout = e_valid && ready_i;
        if (ain) for (int k = 0; k < pc; k++) m_q.push_back(d[(lsb + k)*8 +: 8]);
        if (aout) repeat (8) if (m_q.size() > 0) void'(m_q.pop_front());
        if (e_done) m_drain = 0;
        else if (!m_drain && flush_i) m_drain = 1;
        if (valid_i && !contig) m_err = 1;
        else if (clr_err_i) m_err = 0;
    endtask

    task automatic check_outputs();
        model_outputs();
        chk("ready_o", ready_o, e_ready);
        chk("valid_o", valid_o, e_valid);
        chk("data_o", data_o, e_data);
        chk("mask_o", mask_o, e_mask);
        chk("level_o", level_o, e_level);
        chk("flush_done_o", flush_done_o, e_done);
        chk("err_o", err_o, e_err);
    endtask

    // Driver tasks: inputs change just after a falling edge.
    task automatic drive(input logic v, input logic [3:0] m, input logic [31:0] d,
                         input logic r, input logic f, input logic c);
        valid_i = v; mask_i = m; data_i = d; ready_i = r; flush_i = f; clr_err_i = c;
    endtask

    task automatic finish_cycle();
        check_outputs();
        model_advance();
        @(negedge clk_i);
    endtask

    task automatic step(input logic v, input logic [3:0] m, input logic [31:0] d,
                        input logic r, input logic f, input logic c);
        drive(v, m, d, r, f, c);
        #1;
        finish_cycle();
    endtask

    task automatic drain_all();
        int cyc;
        step(0, 4'h0, 32'h0, 1, 1, 0);
        cyc = 0;
        while (m_drain && cyc < 20) begin
            step(0, 4'h0, 32'h0, 1, 0, 0);
            cyc++;
        end
        chk("drain_timeout", m_drain, 1'b0);
    endtask

    typedef struct {
        logic        v;
        logic [3:0]  m;
        logic [31:0] d;
        logic        r;
        logic        f;
        logic        x_valid;
        logic        x_ready;
        logic [3:0]  x_level;
        logic [63:0] x_data;
        logic [7:0]  x_mask;
        logic        x_done;
    } vec_t;

`ifdef PRIM_PACKER_UNIT_PAD_EN
    localparam logic [63:0] DRAIN_DATA = 64'hEEEE_BBCC_BBCC_BBCC;
    localparam logic [7:0]  DRAIN_MASK = 8'hFF;
`else
    localparam logic [63:0] DRAIN_DATA = 64'h0000_BBCC_BBCC_BBCC;
    localparam logic [7:0]  DRAIN_MASK = 8'h3F;
`endif

    vec_t tbl[12];

    initial begin
        logic [31:0] w0, w1, w2;
        logic [63:0] held;
        int rlsb, rlen;
        logic [3:0] rm;

        // Expected outputs in each row are the values seen before that row's edge.
        tbl[0]  = '{1, 4'hF, 32'h1122_3344, 0, 0, 0, 1, 4'd0, 64'h0, 8'h00, 0};
        tbl[1]  = '{1, 4'hF, 32'h5566_7788, 0, 0, 0, 1, 4'd4, 64'h1122_3344, 8'h0F, 0};
        tbl[2]  = '{0, 4'h0, 32'h0, 1, 0, 1, 1, 4'd8, 64'h5566_7788_1122_3344, 8'hFF, 0};
        tbl[3]  = '{0, 4'h0, 32'h0, 0, 0, 0, 1, 4'd0, 64'h0, 8'h00, 0};
        tbl[4]  = '{1, 4'h6, 32'hAABB_CCDD, 0, 0, 0, 1, 4'd0, 64'h0, 8'h00, 0};
        tbl[5]  = '{1, 4'h6, 32'hAABB_CCDD, 0, 0, 0, 1, 4'd2, 64'hBBCC, 8'h03, 0};
        tbl[6]  = '{1, 4'h6, 32'hAABB_CCDD, 0, 0, 0, 1, 4'd4, 64'hBBCC_BBCC, 8'h0F, 0};
        tbl[7]  = '{0, 4'h0, 32'h0, 0, 1, 0, 1, 4'd6, 64'h0000_BBCC_BBCC_BBCC, 8'h3F, 0};
        tbl[8]  = '{0, 4'h0, 32'h0, 0, 0, 1, 0, 4'd6, DRAIN_DATA, DRAIN_MASK, 0};
        tbl[9]  = '{0, 4'h0, 32'h0, 1, 0, 1, 0, 4'd6, DRAIN_DATA, DRAIN_MASK, 0};
        tbl[10] = '{0, 4'h0, 32'h0, 0, 0, 0, 0, 4'd0, 64'h0, 8'h00, 1};
        tbl[11] = '{0, 4'h0, 32'h0, 0, 0, 0, 1, 4'd0, 64'h0, 8'h00, 0};

        // Reset.
        rst_ni = 1'b0;
        drive(0, 4'h0, 32'h0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk_i);
        #1;
        check_outputs();
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Table vectors: packing, partial masks, flush.
        phase = "table";
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].m, tbl[i].d, tbl[i].r, tbl[i].f, 1'b0);
            #1;
            chk($sformatf("row%0d_valid", i), valid_o, tbl[i].x_valid);
            chk($sformatf("row%0d_ready", i), ready_o, tbl[i].x_ready);
            chk($sformatf("row%0d_level", i), level_o, tbl[i].x_level);
            chk($sformatf("row%0d_data", i), data_o, tbl[i].x_data);
            chk($sformatf("row%0d_mask", i), mask_o, tbl[i].x_mask);
            chk($sformatf("row%0d_done", i), flush_done_o, tbl[i].x_done);
            finish_cycle();
        end

        // Backpressure: three full words with ready_i low, then a stall.
        phase = "backpressure";
        w0 = $urandom(); w1 = $urandom(); w2 = $urandom();
        step(1, 4'hF, w0, 0, 0, 0);
        step(1, 4'hF, w1, 0, 0, 0);
        step(1, 4'hF, w2, 0, 0, 0);
        held = {w1, w0};
        chk("full_level", level_o, 4'd12);
        chk("full_ready", ready_o, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("stall_data", data_o, held);
            step(1, 4'hF, $urandom(), 0, 0, 0);
        end
        step(0, 4'h0, 32'h0, 1, 0, 0);
        chk("after_pop_level", level_o, 4'd4);
        chk("after_pop_ready", ready_o, 1'b1);

        // Simultaneous in/out at level 8.
        phase = "simul";
        step(1, 4'hF, $urandom(), 0, 0, 0);
        chk("pre_level", level_o, 4'd8);
        w0 = $urandom();
        step(1, 4'hF, w0, 1, 0, 0);
        chk("simul_level", level_o, 4'd4);
        chk("simul_low_word", data_o[31:0], w0);
        drain_all();

        // Error flag.
        phase = "err";
        step(1, 4'b1010, 32'h1234_5678, 0, 0, 0);
        chk("err_set", err_o, 1'b1);
        step(1, 4'h3, $urandom(), 0, 0, 0);
        step(0, 4'h0, 32'h0, 0, 0, 0);
        chk("err_hold", err_o, 1'b1);
        step(0, 4'h0, 32'h0, 0, 0, 1);
        chk("err_clr", err_o, 1'b0);
        step(1, 4'b0101, $urandom(), 0, 0, 1);
        chk("err_set_wins", err_o, 1'b1);
        step(0, 4'h0, 32'h0, 0, 0, 1);
        chk("err_clr2", err_o, 1'b0);
        drain_all();

        // Reset in the middle of a drain.
        phase = "reset_mid_drain";
        step(1, 4'b0111, $urandom(), 0, 0, 0);
        step(1, 4'b0111, $urandom(), 0, 0, 0);
        step(0, 4'h0, 32'h0, 0, 1, 0);
        chk("pre_level", level_o, 4'd6);
        chk("pre_valid_drain", valid_o, 1'b1);
        rst_ni = 1'b0;
        model_reset();
        drive(0, 4'h0, 32'h0, 0, 0, 0);
        #1;
        check_outputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            chk("no_done_in_reset", flush_done_o, 1'b0);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("ready_after_reset", ready_o, 1'b1);
        for (int i = 0; i < 3; i++) step(0, 4'h0, 32'h0, 1, 0, 0);

        // Random traffic against the model.
        phase = "random";
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                rlsb = $urandom_range(0, 3);
                rlen = $urandom_range(0, 4 - rlsb);
                rm   = 4'(((1 << rlen) - 1) << rlsb);
            end else begin
                rm = 4'($urandom_range(0, 15));
            end
            step(1'($urandom_range(0, 1)), rm, $urandom(),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 19) == 0));
        end
        drain_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
